// File: rtl/dmem_bridge_if.sv
// dmem_bridge_if: valid/ready memory bus between the data bridge (master) and memory (slave).
interface dmem_bridge_if #(parameter int XLEN = 32);
  logic              req_v;
  logic              req_rdy;
  logic [XLEN-1:0]   adr;
  logic              we;
  logic [XLEN/8-1:0] be;
  logic [XLEN-1:0]   wdata;
  logic              rsp_v;
  logic [XLEN-1:0]   rdata;
  logic              err;
  modport master (output req_v, adr, we, be, wdata, input req_rdy, rsp_v, rdata, err);
  modport slave (input req_v, adr, we, be, wdata, output req_rdy, rsp_v, rdata, err);
endinterface

// File: rtl/dmem_bridge.sv
// dmem_bridge: core load/store port to valid/ready bus bridge, one access in flight.
// Define DMEM_TIMEOUT_EN to add a wait-for-response watchdog of TIMEOUT_CYC cycles.
module dmem_bridge #(
  parameter int XLEN = 32
`ifdef DMEM_TIMEOUT_EN
  , parameter int TIMEOUT_CYC = 255
`endif
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              adr_v_i,
  input  logic [XLEN-1:0]   adr_i,
  input  logic              is_store_i,
  input  logic [XLEN-1:0]   store_data_i,
  input  logic [2:0]        access_size_i,
  output logic              stall_o,
  output logic [XLEN-1:0]   load_data_o,
  output logic              err_o,
  dmem_bridge_if.master     bus
);
  localparam int NB = XLEN / 8;
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;
  state_t state, state_n;
  logic [1:0] a_q, sz_q;
  logic legal, start, timeout;
  logic [NB-1:0] be_n;
  logic [XLEN-1:0] lane, rdata_n;
  always_comb begin
    legal = (access_size_i == 3'b000) |
            (access_size_i == 3'b001 & ~adr_i[0]) |
            (access_size_i == 3'b010 & adr_i[1:0] == 2'b00);
    start = state == S_IDLE & adr_v_i;
    be_n = access_size_i[1:0] == 2'b00 ? NB'(1) << adr_i[1:0] :
           access_size_i[1:0] == 2'b01 ? NB'(3) << adr_i[1:0] : '1;
    lane = bus.rdata >> {a_q, 3'b000};
    rdata_n = bus.we ? '0 :
              sz_q == 2'b00 ? {{(XLEN-8){1'b0}}, lane[7:0]} :
              sz_q == 2'b01 ? {{(XLEN-16){1'b0}}, lane[15:0]} : lane;
    stall_o = start | state == S_REQ | state == S_WAIT;
  end
`ifdef DMEM_TIMEOUT_EN
  logic [7:0] cnt;
  always_ff @(posedge clk)
    cnt <= (!reset_n || state != S_WAIT) ? 8'd0 : cnt + 8'd1;
  assign timeout = state == S_WAIT & ~bus.rsp_v & cnt == 8'(TIMEOUT_CYC - 1);
`else
  assign timeout = 1'b0;
`endif
  always_ff @(posedge clk)
    state <= !reset_n ? S_IDLE : state_n;
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:  state_n = adr_v_i ? (legal ? S_REQ : S_DONE) : S_IDLE;
      S_REQ:   state_n = bus.req_rdy ? S_WAIT : S_REQ;
      S_WAIT:  state_n = (bus.rsp_v | timeout) ? S_DONE : S_WAIT;
      default: state_n = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      bus.req_v   <= 1'b0;
      bus.we      <= 1'b0;
      bus.be      <= '0;
      bus.adr     <= '0;
      bus.wdata   <= '0;
      load_data_o <= '0;
      err_o       <= 1'b0;
      a_q         <= '0;
      sz_q        <= '0;
    end else begin
      if (start & legal) begin
        bus.req_v <= 1'b1;
        bus.we    <= is_store_i;
        bus.be    <= be_n;
        bus.adr   <= {adr_i[XLEN-1:2], 2'b00};
        bus.wdata <= store_data_i << {adr_i[1:0], 3'b000};
        a_q       <= adr_i[1:0];
        sz_q      <= access_size_i[1:0];
      end
      if (start & ~legal) begin
        err_o       <= 1'b1;
        load_data_o <= '0;
      end
      if (state == S_REQ & bus.req_rdy) bus.req_v <= 1'b0;
      if (state == S_WAIT & bus.rsp_v) begin
        load_data_o <= rdata_n;
        err_o       <= bus.err;
      end else if (timeout) begin
        load_data_o <= '0;
        err_o       <= 1'b1;
      end
    end
  end
endmodule
